mem_loader: RTL and testbench



---
 rtl/matrix_mult_pkg.sv | 7 +
 rtl/beat_packer.sv | 36 +++
 rtl/mem_loader.sv | 95 +++++++++
 tb/tb_mem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: loader state encoding and beat-count helper shared by the buffer loaders
package matrix_mult_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_e;
  function automatic int calc_beats(input int lanes, input int width, input int drv_width);
    return lanes * width / drv_width;
  endfunction
endpackage

// File: rtl/beat_packer.sv
// beat_packer: assembles DW-bit beats LSB-first into a BEATS*DW word
module beat_packer #(
  parameter int DW    = 8,
  parameter int BEATS = 4
) (
  input  logic                clk_i,
  input  logic                rstn_async_i,
  input  logic                i_clr,
  input  logic                i_beat_valid,
  input  logic [DW-1:0]       i_beat,
  output logic                o_word_valid,
  output logic [DW*BEATS-1:0] o_word
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [DW*BEATS-1:0] r_buf;
  logic [CW-1:0]       r_cnt;
  logic                w_last;
  assign w_last       = r_cnt == CW'(BEATS - 1);
  assign o_word_valid = i_beat_valid && w_last;
  // o_word already carries the incoming beat so the final beat needs no extra cycle
  always_comb begin
    o_word = r_buf;
    o_word[r_cnt*DW +: DW] = i_beat;
  end
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_beat_valid) begin
      r_buf <= o_word;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: packs driver beats into memory words written to consecutive addresses.
// Defining MEM_LOADER_CHECKSUM_EN adds checksum_o, a running XOR of the written words.
module mem_loader
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter int DRIVER_WIDTH = 8,
  parameter int SIZE         = 256
) (
  input  logic                     clk_i,
  input  logic                     rstn_async_i,
  input  logic                     start_i,
  input  logic [$clog2(SIZE)-1:0]  base_addr_i,
  input  logic [$clog2(SIZE):0]    num_words_i,
  input  logic [DRIVER_WIDTH-1:0]  drv_data_i,
  input  logic                     drv_valid_i,
  output logic                     drv_ready_o,
  output logic                     mem_cenb_o,
  output logic                     mem_wenb_o,
  output logic [$clog2(SIZE)-1:0]  mem_addr_o,
  output logic [LANES*WIDTH-1:0]   mem_d_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [LANES*WIDTH-1:0]   checksum_o
`endif
);
  localparam int AW    = $clog2(SIZE);
  localparam int DW    = LANES * WIDTH;
  localparam int BEATS = calc_beats(LANES, WIDTH, DRIVER_WIDTH);
  loader_state_e r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_left;
  logic          w_start, w_word_valid;
  logic [DW-1:0] w_word;
  assign w_start = start_i && r_state == IDLE;
  beat_packer #(.DW(DRIVER_WIDTH), .BEATS(BEATS)) u_packer (
    .clk_i       (clk_i),
    .rstn_async_i(rstn_async_i),
    .i_clr       (w_start),
    .i_beat_valid(drv_valid_i && drv_ready_o),
    .i_beat      (drv_data_i),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start_i) w_next = num_words_i == '0 ? DONE : LOAD;
      LOAD:  if (w_word_valid && r_left == (AW+1)'(1)) w_next = FLUSH;
      FLUSH: w_next = DONE;
      DONE:  w_next = IDLE;
    endcase
  end
  // status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      drv_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_cenb_o  <= 1'b1;
      mem_wenb_o  <= 1'b1;
      mem_addr_o  <= '0;
      mem_d_o     <= '0;
    end else begin
      r_state     <= w_next;
      drv_ready_o <= w_next == LOAD;
      busy_o      <= w_next != IDLE;
      done_o      <= w_next == DONE;
      mem_cenb_o  <= !w_word_valid;
      mem_wenb_o  <= !w_word_valid;
      if (w_start) begin
        r_addr <= base_addr_i;
        r_left <= num_words_i;
      end else if (w_word_valid) begin
        mem_addr_o <= r_addr;
        mem_d_o    <= w_word;
        r_addr     <= r_addr == AW'(SIZE - 1) ? '0 : r_addr + 1'b1;
        r_left     <= r_left - 1'b1;
      end
    end
  end
`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) checksum_o <= '0;
    else if (w_start) checksum_o <= '0;
    else if (!mem_cenb_o) checksum_o <= checksum_o ^ mem_d_o;
  end
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized mem_loader bench checked every cycle against a transaction-level model
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        rstn_async_i, start_i, drv_valid_i;
  logic [7:0]  base_addr_i, drv_data_i;
  logic [8:0]  num_words_i;
  logic        drv_ready_o, mem_cenb_o, mem_wenb_o, busy_o, done_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_d_o;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif
  mem_loader dut (
    .clk_i       (clk),
    .rstn_async_i(rstn_async_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .drv_data_i  (drv_data_i),
    .drv_valid_i (drv_valid_i),
    .drv_ready_o (drv_ready_o),
    .mem_cenb_o  (mem_cenb_o),
    .mem_wenb_o  (mem_wenb_o),
    .mem_addr_o  (mem_addr_o),
    .mem_d_o     (mem_d_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    .checksum_o  (checksum_o)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ntest = 0, nfail = 0;
  typedef struct {logic [7:0] a; logic [31:0] d; int due;} wr_t;
  wr_t         q[$];
  logic [7:0]  obs_a[$];
  logic [31:0] obs_d[$];
  int          obs_c[$], done_c[$];
  logic [7:0]  bq[$];
  int          busy_from = 0, busy_to = -1, m_left = 0, m_k = 0;
  bit          m_load = 0;
  logic [7:0]  m_addr;
  logic [31:0] m_word, m_chk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // cycle-level model: a load is a word list due one cycle after its last beat is taken
  task automatic monitor();
    bit eb, er, es;
    forever begin
      @(negedge clk);
      if (!rstn_async_i) begin
        chk("reset_outputs", {mem_cenb_o, mem_wenb_o, drv_ready_o, busy_o, done_o, mem_addr_o, mem_d_o},
            {2'b11, 3'b000, 8'h00, 32'h0});
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("reset_checksum", checksum_o, 0);
`endif
        q.delete();
        busy_from = 0; busy_to = -1; m_load = 0;
      end else begin
        eb = cyc >= busy_from && cyc <= busy_to;
        er = m_load && cyc >= busy_from;
        es = q.size() > 0 && q[0].due == cyc;
        chk("busy", busy_o, eb);
        chk("ready", drv_ready_o, er);
        chk("done", done_o, cyc == busy_to);
        chk("cenb", mem_cenb_o, !es);
        chk("wenb", mem_wenb_o, !es);
        if (!mem_cenb_o) begin
          obs_a.push_back(mem_addr_o); obs_d.push_back(mem_d_o); obs_c.push_back(cyc);
        end
        if (es) begin
          chk("addr", mem_addr_o, q[0].a);
          chk("data", mem_d_o, q[0].d);
          void'(q.pop_front());
        end
        if (done_o) done_c.push_back(cyc);
`ifdef MEM_LOADER_CHECKSUM_EN
        if (cyc == busy_to) chk("checksum", checksum_o, m_chk);
`endif
        if (start_i && !eb) begin
          busy_from = cyc + 1;
          m_chk = 0; m_addr = base_addr_i; m_left = int'(num_words_i); m_k = 0; m_word = 0;
          m_load = num_words_i != 0;
          busy_to = num_words_i == 0 ? cyc + 1 : 1 << 30;
        end
        if (drv_valid_i && er) begin
          m_word[m_k*8 +: 8] = drv_data_i;
          m_k++;
          if (m_k == 4) begin
            q.push_back('{m_addr, m_word, cyc + 1});
            m_chk ^= m_word;
            m_addr = m_addr + 8'd1;
            m_left--; m_k = 0; m_word = 0;
            if (m_left == 0) begin
              m_load = 0;
              busy_to = cyc + 2;
            end
          end
        end
      end
    end
  endtask
  task automatic start_load(input logic [7:0] b, input logic [8:0] n);
    @(posedge clk); #1;
    start_i = 1; base_addr_i = b; num_words_i = n;
    @(posedge clk); #1;
    start_i = 0; base_addr_i = 8'($urandom); num_words_i = 9'($urandom);
  endtask
  task automatic send(input int gmin, input int gmax);
    foreach (bq[i]) begin
      bit acc;
      int w;
      drv_valid_i = 1; drv_data_i = bq[i]; w = 0;
      do begin
        @(negedge clk); acc = drv_ready_o;
        @(posedge clk); #1; w++;
      end while (!acc && w < 100);
      if (!acc) chk("beat_timeout", 0, 1);
      drv_valid_i = 0; drv_data_i = 8'($urandom);
      repeat ($urandom_range(gmin, gmax)) begin @(posedge clk); #1; end
    end
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !busy_o;
    end
    chk("idle_timeout", ok, 1);
  endtask
  task automatic fixed_beats();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask
  initial begin
    int ob, nd, s;
    rstn_async_i = 1; start_i = 0; drv_valid_i = 0;
    base_addr_i = 0; num_words_i = 0; drv_data_i = 0;
    #1 rstn_async_i = 0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rstn_async_i = 1;
    // reset after the 2nd beat of a load
    start_load(8'h05, 9'd3);
    bq = '{8'hA1, 8'hA2};
    send(0, 0);
    @(posedge clk); #2 rstn_async_i = 0;
    #1 chk("async_reset", {mem_cenb_o, mem_wenb_o, drv_ready_o, busy_o, done_o, mem_addr_o, mem_d_o},
           {2'b11, 3'b000, 8'h00, 32'h0});
    repeat (2) @(posedge clk);
    #1 rstn_async_i = 1;
    repeat (2) @(posedge clk);
    // basic back-to-back load
    ob = obs_a.size();
    start_load(8'h10, 9'd2);
    fixed_beats(); send(0, 0); wait_idle();
    chk("basic_count", obs_a.size() - ob, 2);
    chk("basic_a0", obs_a[ob], 8'h10);
    chk("basic_d0", obs_d[ob], 32'h44332211);
    chk("basic_a1", obs_a[ob+1], 8'h11);
    chk("basic_d1", obs_d[ob+1], 32'h88776655);
    chk("basic_spacing", obs_c[ob+1] - obs_c[ob], 4);
    chk("basic_done_cyc", done_c[done_c.size()-1], obs_c[ob+1] + 1);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum_lit", checksum_o, 32'hCC444444);
`endif
    // valid toggling 1/0
    ob = obs_a.size();
    start_load(8'h20, 9'd2);
    fixed_beats(); send(1, 1); wait_idle();
    chk("thr_d0", obs_d[ob], 32'h44332211);
    chk("thr_d1", obs_d[ob+1], 32'h88776655);
    chk("thr_spacing", obs_c[ob+1] - obs_c[ob], 8);
    // address wrap
    ob = obs_a.size();
    start_load(8'hFF, 9'd2);
    fixed_beats(); send(0, 0); wait_idle();
    chk("wrap_a0", obs_a[ob], 8'hFF);
    chk("wrap_a1", obs_a[ob+1], 8'h00);
    // zero words
    ob = obs_a.size(); nd = done_c.size();
    start_load(8'h30, 9'd0);
    s = cyc;
    wait_idle();
    chk("zero_done_count", done_c.size() - nd, 1);
    chk("zero_done_cyc", done_c[done_c.size()-1], s);
    chk("zero_no_write", obs_a.size() - ob, 0);
    // start while busy is ignored
    ob = obs_a.size();
    start_load(8'h40, 9'd2);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04}; send(0, 0);
    start_load(8'h50, 9'd1);
    bq = '{8'h05, 8'h06, 8'h07, 8'h08}; send(0, 0);
    wait_idle();
    chk("busy_start_count", obs_a.size() - ob, 2);
    chk("busy_start_a1", obs_a[ob+1], 8'h41);
    chk("busy_start_d1", obs_d[ob+1], 32'h08070605);
    // randomized loads
    for (int t = 0; t < 25; t++) begin
      int n, g;
      n = $urandom_range(0, 4);
      g = $urandom_range(0, 2);
      start_load(8'($urandom), 9'(n));
      bq.delete();
      for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
      send(0, g);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
